// File: rtl/uart_tx_engine_if.sv
// Byte-load and serial-line signals shared between a UART transmit engine and
// the bus agent that feeds it.
interface uart_tx_engine_if;
  logic       load;
  logic [7:0] data;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic [3:0] baud_val;
  logic       tx;
  logic       tx_rdy;

  modport master (
    output load, data, bit8, parity_en, odd_n_even, baud_val,
    input  tx, tx_rdy
  );

  modport slave (
    input  load, data, bit8, parity_en, odd_n_even, baud_val,
    output tx, tx_rdy
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, 7/8 data bits LSB first, optional parity, one
// stop bit, with the bit time taken from a 4-bit baud select.
module uart_tx_engine #(
  parameter bit FAST_SIM = 1'b0
) (
  input logic             clk,
  input logic             reset,
  uart_tx_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic [18:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        bit8_q, bit8_d;
  logic        par_en_q, par_en_d;
  logic [3:0]  baud_q, baud_d;
  logic        tx_q, tx_d;
  logic        tx_rdy_q, tx_rdy_d;

  logic [18:0] div_last;
  logic        bit_end;
  logic [2:0]  last_bit;

  // Last count value of a bit period (divisor - 1) for the captured baud select.
  always_comb begin
    div_last = 19'd108;
    if (FAST_SIM) begin
      div_last = 19'd15;
    end else begin
      case (baud_q)
        4'd0:    div_last = 19'd333332;
        4'd1:    div_last = 19'd83332;
        4'd2:    div_last = 19'd41666;
        4'd3:    div_last = 19'd20832;
        4'd4:    div_last = 19'd10416;
        4'd5:    div_last = 19'd5207;
        4'd6:    div_last = 19'd2603;
        4'd7:    div_last = 19'd1735;
        4'd8:    div_last = 19'd867;
        4'd9:    div_last = 19'd433;
        4'd10:   div_last = 19'd216;
        default: div_last = 19'd108;
      endcase
    end
  end

  assign bit_end  = (baud_cnt_q == div_last);
  assign last_bit = bit8_q ? 3'd7 : 3'd6;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit8_d     = bit8_q;
    par_en_d   = par_en_q;
    baud_d     = baud_q;
    tx_d       = tx_q;
    tx_rdy_d   = tx_rdy_q;

    if (state_q == IDLE) begin
      if (bus.load) begin
        // Parity is fixed at load time so later input changes cannot disturb it.
        shift_d    = bus.data;
        par_d      = (^(bus.data & {bus.bit8, 7'h7f})) ^ bus.odd_n_even;
        bit8_d     = bus.bit8;
        par_en_d   = bus.parity_en;
        baud_d     = bus.baud_val;
        baud_cnt_d = 19'd0;
        bit_cnt_d  = 3'd0;
        tx_d       = 1'b0;
        tx_rdy_d   = 1'b0;
        state_d    = START;
      end
    end else if (!bit_end) begin
      baud_cnt_d = baud_cnt_q + 19'd1;
    end else begin
      baud_cnt_d = 19'd0;
      case (state_q)
        START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q == last_bit) begin
            if (par_en_q) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          tx_d     = 1'b1;
          tx_rdy_d = 1'b1;
          state_d  = IDLE;
        end
        default: begin
          tx_d     = 1'b1;
          tx_rdy_d = 1'b1;
          state_d  = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= 19'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      bit8_q     <= 1'b0;
      par_en_q   <= 1'b0;
      baud_q     <= 4'd0;
      tx_q       <= 1'b1;
      tx_rdy_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit8_q     <= bit8_d;
      par_en_q   <= par_en_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      tx_rdy_q   <= tx_rdy_d;
    end
  end

  assign bus.tx     = tx_q;
  assign bus.tx_rdy = tx_rdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a fast-sim instance and a real-divisor instance,
// each frame compared cycle by cycle against a frame built from framing rules.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_f, load_s;
  logic [7:0] data_in;
  logic       bit8_in, pe_in, odd_in;
  logic [3:0] baud_in;
  logic       use_slow;
  logic       tx_obs, rdy_obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       bit8;
    logic       pe;
    logic       odd;
    logic [3:0] baud;
    logic       slow;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  vec_t vecs[11];
  logic exp_bits[$];

  always #5 clk = ~clk;

  uart_tx_engine_if fast_if ();
  uart_tx_engine_if slow_if ();

  assign fast_if.load       = load_f;
  assign fast_if.data       = data_in;
  assign fast_if.bit8       = bit8_in;
  assign fast_if.parity_en  = pe_in;
  assign fast_if.odd_n_even = odd_in;
  assign fast_if.baud_val   = baud_in;
  assign slow_if.load       = load_s;
  assign slow_if.data       = data_in;
  assign slow_if.bit8       = bit8_in;
  assign slow_if.parity_en  = pe_in;
  assign slow_if.odd_n_even = odd_in;
  assign slow_if.baud_val   = baud_in;

  assign tx_obs  = use_slow ? slow_if.tx : fast_if.tx;
  assign rdy_obs = use_slow ? slow_if.tx_rdy : fast_if.tx_rdy;

  uart_tx_engine #(.FAST_SIM(1'b1)) dut_fast (.clk(clk), .reset(reset), .bus(fast_if.slave));
  uart_tx_engine #(.FAST_SIM(1'b0)) dut_slow (.clk(clk), .reset(reset), .bus(slow_if.slave));

  function automatic int refDiv(input logic slow, input logic [3:0] baud);
    if (!slow) return 16;
    case (baud)
      4'd0:    return 333333;
      4'd1:    return 83333;
      4'd2:    return 41667;
      4'd3:    return 20833;
      4'd4:    return 10417;
      4'd5:    return 5208;
      4'd6:    return 2604;
      4'd7:    return 1736;
      4'd8:    return 868;
      4'd9:    return 434;
      4'd10:   return 217;
      default: return 109;
    endcase
  endfunction

  // Reference frame as a list of line levels, one entry per bit time.
  task automatic buildFrame(input vec_t v);
    int nd;
    logic p;
    nd = v.bit8 ? 8 : 7;
    p  = v.odd;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      exp_bits.push_back(v.data[i]);
      p = p ^ v.data[i];
    end
    if (v.pe) exp_bits.push_back(p);
    exp_bits.push_back(1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Loads one byte, then follows the whole frame cycle by cycle; optionally
  // pokes a second load and changed settings mid-frame.
  task automatic applyStimulus(input vec_t v, input bit disturb, input bit release_rst);
    int div, total, bad, low_cnt, nd;
    logic rx_bits[$];
    logic [7:0] rx_byte, want;
    buildFrame(v);
    div   = refDiv(v.slow, v.baud);
    total = exp_bits.size() * div;
    nd    = v.bit8 ? 8 : 7;
    @(negedge clk);
    use_slow = v.slow;
    data_in  = v.data;
    bit8_in  = v.bit8;
    pe_in    = v.pe;
    odd_in   = v.odd;
    baud_in  = v.baud;
    if (v.slow) load_s = 1'b1; else load_f = 1'b1;
    if (release_rst) reset = 1'b1;
    @(posedge clk);
    #1;
    load_f = 1'b0;
    load_s = 1'b0;
    bad = 0;
    low_cnt = 0;
    rx_bits.delete();
    for (int c = 0; c < total; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (tx_obs !== exp_bits[c / div]) bad++;
      if (rdy_obs === 1'b0) low_cnt++;
      if ((c % div) == div / 2) rx_bits.push_back(tx_obs);
      if (disturb && c == 3 * div + 2) begin
        if (v.slow) load_s = 1'b1; else load_f = 1'b1;
        data_in = 8'($urandom);
        bit8_in = ~bit8_in;
        pe_in   = ~pe_in;
        odd_in  = ~odd_in;
        baud_in = baud_in + 4'd1;
      end
      if (disturb && c == 3 * div + 3) begin
        load_f = 1'b0;
        load_s = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("rdy_after_frame", rdy_obs, 1);
    checkOutput("tx_after_frame", tx_obs, 1);
    checkOutput("tx_waveform_bad_cycles", bad, 0);
    checkOutput("rdy_low_cycles", low_cnt, v.exp_len * div);
    rx_byte = 8'h00;
    for (int i = 0; i < nd; i++) rx_byte[i] = rx_bits[1 + i];
    want = v.bit8 ? v.data : {1'b0, v.data[6:0]};
    checkOutput("rx_start_bit", rx_bits[0], 0);
    checkOutput("rx_data", rx_byte, want);
    if (v.pe) checkOutput("rx_parity", rx_bits[1 + nd], v.exp_par);
  endtask

  initial begin
    vec_t r;
    int nd;
    logic p;

    vecs[0]  = '{8'h41, 1'b1, 1'b0, 1'b0, 4'd4,  1'b0, 10, 1'b0};
    vecs[1]  = '{8'h41, 1'b1, 1'b1, 1'b0, 4'd4,  1'b0, 11, 1'b0};
    vecs[2]  = '{8'h41, 1'b1, 1'b1, 1'b1, 4'd4,  1'b0, 11, 1'b1};
    vecs[3]  = '{8'hC1, 1'b0, 1'b1, 1'b0, 4'd4,  1'b0, 10, 1'b0};
    vecs[4]  = '{8'h55, 1'b1, 1'b0, 1'b0, 4'd2,  1'b0, 10, 1'b0};
    vecs[5]  = '{8'hAA, 1'b1, 1'b0, 1'b0, 4'd2,  1'b0, 10, 1'b0};
    vecs[6]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 4'd10, 1'b1, 10, 1'b0};
    vecs[7]  = '{8'h3C, 1'b0, 1'b1, 1'b1, 4'd11, 1'b1, 10, 1'b1};
    vecs[8]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 11, 1'b0};
    vecs[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 4'd9,  1'b1, 9,  1'b0};
    vecs[10] = '{8'h5A, 1'b1, 1'b1, 1'b0, 4'd8,  1'b1, 11, 1'b0};

    // Reset held with load high: line idle, load only taken after release.
    use_slow = 1'b0;
    reset    = 1'b0;
    load_f   = 1'b1;
    load_s   = 1'b0;
    data_in  = 8'h41;
    bit8_in  = 1'b1;
    pe_in    = 1'b0;
    odd_in   = 1'b0;
    baud_in  = 4'd4;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("reset_tx", tx_obs, 1);
      checkOutput("reset_rdy", rdy_obs, 1);
    end
    applyStimulus(vecs[0], 1'b0, 1'b1);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], (i == 4 || i == 5), 1'b0);

    // Reset during data bit 3 of an all-zero byte aborts the frame at once.
    @(negedge clk);
    use_slow = 1'b0;
    data_in  = 8'h00;
    bit8_in  = 1'b1;
    pe_in    = 1'b0;
    odd_in   = 1'b0;
    baud_in  = 4'd0;
    load_f   = 1'b1;
    @(posedge clk);
    #1;
    load_f = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    checkOutput("mid_frame_tx_low", tx_obs, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_tx", tx_obs, 1);
    checkOutput("abort_rdy", rdy_obs, 1);
    @(negedge clk);
    reset = 1'b1;
    r = '{8'h0F, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 10, 1'b0};
    applyStimulus(r, 1'b0, 1'b0);

    // Randomized back-to-back frames on the fast instance.
    for (int n = 0; n < 20; n++) begin
      r.data = 8'($urandom);
      r.bit8 = 1'($urandom_range(0, 1));
      r.pe   = 1'($urandom_range(0, 1));
      r.odd  = 1'($urandom_range(0, 1));
      r.baud = 4'($urandom_range(0, 15));
      r.slow = 1'b0;
      nd = r.bit8 ? 8 : 7;
      p  = r.odd;
      for (int i = 0; i < nd; i++) p = p ^ r.data[i];
      r.exp_par = p;
      r.exp_len = 2 + nd + (r.pe ? 1 : 0);
      applyStimulus(r, ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial transmitter for the local-bus UART.
- Accepts one byte per load strobe and serialises it on `tx`: start bit, 7 or 8 data bits LSB first, optional parity, one stop bit.
- Uses the same framing controls (`bit8`, `parity_en`, `odd_n_even`) and 4-bit baud select as the receive path, so a frame it sends is accepted by the UART receiver under identical settings.

Parameters:
- FAST_SIM, 0: when 1, every baud_val selects 16 clocks per bit (simulation speed-up); when 0, the 100 MHz divisor table below is used.

Ports:
- clk  input  1  system clock, 100 MHz, rising edge.
- reset  input  1  synchronous, active-low reset.
- load  input  1  write strobe; accepted only when tx_rdy=1.
- data  input  8  byte to send; sampled on an accepted load.
- bit8  input  1  1 = 8 data bits, 0 = 7 data bits (data[7] not sent).
- parity_en  input  1  1 = append parity bit.
- odd_n_even  input  1  1 = odd parity, 0 = even parity.
- baud_val  input  4  baud select.
- tx  output  1  serial line, idles high.
- tx_rdy  output  1  1 = idle and able to accept a load.

Behaviour:
- Reset (reset=0 at a rising edge): tx=1, tx_rdy=1, state=IDLE, bit and baud counters cleared.
  - Reset takes priority over everything, including a frame in progress; the frame is aborted with no partial stop bit.
- Divisor (clocks per bit, FAST_SIM=0), indexed by baud_val:
  - 0=333333, 1=83333, 2=41667, 3=20833, 4=10417, 5=5208
  - 6=2604, 7=1736, 8=868, 9=434, 10=217
  - 11..15=109
  - Baud counter is 19 bits, counts 0..divisor-1, then wraps.
- Load acceptance:
  - load=1 with tx_rdy=1 captures data, bit8, parity_en, odd_n_even and baud_val into internal registers.
  - tx_rdy goes 0 on the same edge. Later input changes have no effect on the frame.
  - load=1 with tx_rdy=0 is ignored: no queueing, no error flag.
- State machine, advancing one bit per divisor period:
  - IDLE: tx=1. Accepted load -> START.
  - START: tx=0 for one bit time, beginning the cycle after the load edge. -> DATA.
  - DATA: tx=shift[0], LSB first. Runs 8 bits (bit8=1) or 7 bits (bit8=0). -> PARITY if parity_en, else STOP.
  - PARITY: tx = XOR of the transmitted data bits, XOR odd_n_even. With bit8=0, data[7] is excluded. -> STOP.
  - STOP: tx=1 for one bit time -> IDLE.
- tx_rdy returns to 1 on the edge that ends the stop bit.
- A load in that same cycle, or any later cycle, is accepted, giving back-to-back frames with no extra idle time.
- Frame length: 9 to 11 bits × divisor clocks. All bit times are exact; there is no fractional accumulation.
- tx is registered (glitch-free) and changes only on bit boundaries.
- Simultaneous load and reset: reset wins; the byte is dropped.

Test Plan:
- Reset with load held high: tx=1 and tx_rdy=1 for the whole reset period; release reset -> load accepted on the first edge after release.
- baud_val=4, bit8=1, parity_en=0, load data=0x41:
  - tx = 0,1,0,0,0,0,0,1,0,1, each bit exactly 10417 clocks.
  - tx_rdy low for exactly 104170 clocks.
  - Loopback into the UART receiver yields data_out=0x41.
- 0x41 with parity_en=1: even parity (odd_n_even=0) -> parity bit 0; odd parity (odd_n_even=1) -> parity bit 1; frame is 11 bits in both cases.
- bit8=0, data=0xC1, parity_en=1, even parity:
  - data bits sent = 1,0,0,0,0,0,1; data[7] is not sent.
  - parity bit = 0; frame is 10 bits.
- FAST_SIM=1:
  - Second load issued mid-frame is ignored.
  - Load issued in the cycle tx_rdy rises starts the start bit on the next cycle; both bytes (0x55 then 0xAA) arrive intact.
  - Changing baud_val or bit8 mid-frame does not alter bit timing or bit count.
- Reset asserted during DATA bit 3 -> tx=1 and tx_rdy=1 on the next edge; a new load of 0x0F afterwards transmits a clean frame.
